// File: rtl/ex_mem_latch_if.sv
// EX->MEM pipeline bus: EX-stage inputs (i_*) and registered MEM-stage outputs (o_*).
interface ex_mem_latch_if #(
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned PC_SIZE       = 32
);
  logic                     i_enable;
  logic                     i_flush;
  logic [DATA_SIZE-1:0]     i_alu_result;
  logic                     i_zero;
  logic [DATA_SIZE-1:0]     i_write_data;
  logic [REG_ADDR_SIZE-1:0] i_rd_addr;
  logic [PC_SIZE-1:0]       i_pc_link;
  logic [PC_SIZE-1:0]       i_branch_target;
  logic                     i_branch;
  logic                     i_link;
  logic                     i_mem_read;
  logic                     i_mem_write;
  logic [1:0]               i_mem_size;
  logic                     i_mem_unsigned;
  logic                     i_mem_to_reg;
  logic                     i_reg_write;
  logic                     i_halt;

  logic [DATA_SIZE-1:0]     o_result;
  logic [DATA_SIZE-1:0]     o_store_data;
  logic [3:0]               o_byte_en;
  logic [REG_ADDR_SIZE-1:0] o_rd_addr;
  logic                     o_pcsrc;
  logic [PC_SIZE-1:0]       o_branch_target;
  logic                     o_mem_read;
  logic                     o_mem_write;
  logic [1:0]               o_mem_size;
  logic                     o_mem_unsigned;
  logic                     o_mem_to_reg;
  logic                     o_reg_write;
  logic                     o_halt;
  logic                     o_misaligned;

  modport slave (
    input  i_enable, i_flush, i_alu_result, i_zero, i_write_data, i_rd_addr,
           i_pc_link, i_branch_target, i_branch, i_link, i_mem_read, i_mem_write,
           i_mem_size, i_mem_unsigned, i_mem_to_reg, i_reg_write, i_halt,
    output o_result, o_store_data, o_byte_en, o_rd_addr, o_pcsrc, o_branch_target,
           o_mem_read, o_mem_write, o_mem_size, o_mem_unsigned, o_mem_to_reg,
           o_reg_write, o_halt, o_misaligned
  );

  modport master (
    output i_enable, i_flush, i_alu_result, i_zero, i_write_data, i_rd_addr,
           i_pc_link, i_branch_target, i_branch, i_link, i_mem_read, i_mem_write,
           i_mem_size, i_mem_unsigned, i_mem_to_reg, i_reg_write, i_halt,
    input  o_result, o_store_data, o_byte_en, o_rd_addr, o_pcsrc, o_branch_target,
           o_mem_read, o_mem_write, o_mem_size, o_mem_unsigned, o_mem_to_reg,
           o_reg_write, o_halt, o_misaligned
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: branch resolution, store lane formatting and
// misalignment squash, with stall (enable) and bubble (flush) support.
module ex_mem_latch #(
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned PC_SIZE       = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  ex_mem_latch_if.slave bus
);
  logic [DATA_SIZE-1:0]     w_result;
  logic [DATA_SIZE-1:0]     w_store_data;
  logic [3:0]               w_lane_en;
  logic [3:0]               w_byte_en;
  logic [1:0]               w_addr_lo;
  logic                     w_unaligned;
  logic                     w_fault;

  logic [DATA_SIZE-1:0]     r_result;
  logic [DATA_SIZE-1:0]     r_store_data;
  logic [3:0]               r_byte_en;
  logic [REG_ADDR_SIZE-1:0] r_rd_addr;
  logic                     r_pcsrc;
  logic [PC_SIZE-1:0]       r_branch_target;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic [1:0]               r_mem_size;
  logic                     r_mem_unsigned;
  logic                     r_mem_to_reg;
  logic                     r_reg_write;
  logic                     r_halt;
  logic                     r_misaligned;

  // Next-state datapath: result mux, lane replication and alignment check.
  always_comb begin
    w_addr_lo    = bus.i_alu_result[1:0];
    w_result     = bus.i_link ? DATA_SIZE'(bus.i_pc_link) : bus.i_alu_result;
    w_store_data = bus.i_write_data;
    w_lane_en    = 4'b1111;
    w_unaligned  = 1'b0;
    case (bus.i_mem_size)
      2'b00: begin
        w_store_data = DATA_SIZE'({4{bus.i_write_data[7:0]}});
        w_lane_en    = 4'(4'b0001 << w_addr_lo);
      end
      2'b01: begin
        w_store_data = DATA_SIZE'({2{bus.i_write_data[15:0]}});
        w_lane_en    = w_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_unaligned  = w_addr_lo[0];
      end
      default: begin
        w_unaligned  = |w_addr_lo;
      end
    endcase
    w_fault   = w_unaligned & (bus.i_mem_read | bus.i_mem_write);
    w_byte_en = (bus.i_mem_write & ~w_fault) ? w_lane_en : 4'b0000;
  end

  // Pipeline register: hold on !enable, bubble on flush, else capture.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_result        <= '0;
      r_store_data    <= '0;
      r_byte_en       <= '0;
      r_rd_addr       <= '0;
      r_pcsrc         <= 1'b0;
      r_branch_target <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_size      <= '0;
      r_mem_unsigned  <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_reg_write     <= 1'b0;
      r_halt          <= 1'b0;
      r_misaligned    <= 1'b0;
    end else if (bus.i_enable) begin
      if (bus.i_flush) begin
        r_result        <= '0;
        r_store_data    <= '0;
        r_byte_en       <= '0;
        r_rd_addr       <= '0;
        r_pcsrc         <= 1'b0;
        r_branch_target <= '0;
        r_mem_read      <= 1'b0;
        r_mem_write     <= 1'b0;
        r_mem_size      <= '0;
        r_mem_unsigned  <= 1'b0;
        r_mem_to_reg    <= 1'b0;
        r_reg_write     <= 1'b0;
        r_halt          <= 1'b0;
        r_misaligned    <= 1'b0;
      end else begin
        r_result        <= w_result;
        r_store_data    <= w_store_data;
        r_byte_en       <= w_byte_en;
        r_rd_addr       <= bus.i_rd_addr;
        r_pcsrc         <= bus.i_branch & bus.i_zero;
        r_branch_target <= bus.i_branch_target;
        r_mem_read      <= bus.i_mem_read & ~w_fault;
        r_mem_write     <= bus.i_mem_write & ~w_fault;
        r_mem_size      <= bus.i_mem_size;
        r_mem_unsigned  <= bus.i_mem_unsigned;
        r_mem_to_reg    <= bus.i_mem_to_reg;
        r_reg_write     <= bus.i_reg_write & ~w_fault;
        r_halt          <= bus.i_halt;
        r_misaligned    <= w_fault;
      end
    end
  end

  assign bus.o_result        = r_result;
  assign bus.o_store_data    = r_store_data;
  assign bus.o_byte_en       = r_byte_en;
  assign bus.o_rd_addr       = r_rd_addr;
  assign bus.o_pcsrc         = r_pcsrc;
  assign bus.o_branch_target = r_branch_target;
  assign bus.o_mem_read      = r_mem_read;
  assign bus.o_mem_write     = r_mem_write;
  assign bus.o_mem_size      = r_mem_size;
  assign bus.o_mem_unsigned  = r_mem_unsigned;
  assign bus.o_mem_to_reg    = r_mem_to_reg;
  assign bus.o_reg_write     = r_reg_write;
  assign bus.o_halt          = r_halt;
  assign bus.o_misaligned    = r_misaligned;
endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: expected MEM-stage word queued at drive
// time, popped and compared one edge later.
module tb_ex_mem_latch;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;

  ex_mem_latch_if #(.DATA_SIZE(32), .REG_ADDR_SIZE(5), .PC_SIZE(32)) bus ();

  ex_mem_latch #(.DATA_SIZE(32), .REG_ADDR_SIZE(5), .PC_SIZE(32)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [3:0]  byte_en;
    logic [4:0]  rd_addr;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        mem_to_reg;
    logic        reg_write;
    logic        halt;
    logic        misaligned;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".result"},     bus.o_result,                 e.result);
    check({tag, ".store_data"}, bus.o_store_data,             e.store_data);
    check({tag, ".byte_en"},    32'(bus.o_byte_en),           32'(e.byte_en));
    check({tag, ".rd_addr"},    32'(bus.o_rd_addr),           32'(e.rd_addr));
    check({tag, ".pcsrc"},      32'(bus.o_pcsrc),             32'(e.pcsrc));
    check({tag, ".target"},     bus.o_branch_target,          e.branch_target);
    check({tag, ".ctrl"},
          32'({bus.o_mem_read, bus.o_mem_write, bus.o_mem_size, bus.o_mem_unsigned,
               bus.o_mem_to_reg, bus.o_reg_write, bus.o_halt, bus.o_misaligned}),
          32'({e.mem_read, e.mem_write, e.mem_size, e.mem_unsigned,
               e.mem_to_reg, e.reg_write, e.halt, e.misaligned}));
  endtask

  // Reference behaviour of one capture from the current EX inputs.
  function automatic exp_t model();
    exp_t       e;
    logic [1:0] a;
    logic [3:0] lanes;
    logic       bad_align;
    logic       fault;
    logic [31:0] wd;
    e = '0;
    if (bus.i_flush) return e;
    a  = bus.i_alu_result[1:0];
    wd = bus.i_write_data;
    e.result        = bus.i_link ? bus.i_pc_link : bus.i_alu_result;
    e.pcsrc         = bus.i_branch && bus.i_zero;
    e.rd_addr       = bus.i_rd_addr;
    e.branch_target = bus.i_branch_target;
    e.mem_size      = bus.i_mem_size;
    e.mem_unsigned  = bus.i_mem_unsigned;
    e.mem_to_reg    = bus.i_mem_to_reg;
    e.halt          = bus.i_halt;
    if (bus.i_mem_size == 2'b00) begin
      e.store_data = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      lanes        = (a == 0) ? 4'b0001 : (a == 1) ? 4'b0010 : (a == 2) ? 4'b0100 : 4'b1000;
      bad_align    = 1'b0;
    end else if (bus.i_mem_size == 2'b01) begin
      e.store_data = {wd[15:0], wd[15:0]};
      lanes        = (a >= 2) ? 4'b1100 : 4'b0011;
      bad_align    = (a == 1) || (a == 3);
    end else begin
      e.store_data = wd;
      lanes        = 4'b1111;
      bad_align    = (a != 0);
    end
    fault        = bad_align && (bus.i_mem_read || bus.i_mem_write);
    e.misaligned = fault;
    e.mem_read   = bus.i_mem_read && !fault;
    e.mem_write  = bus.i_mem_write && !fault;
    e.reg_write  = bus.i_reg_write && !fault;
    e.byte_en    = e.mem_write ? lanes : 4'b0000;
    return e;
  endfunction

  task automatic clear_inputs();
    bus.i_enable = 1'b1; bus.i_flush = 1'b0;
    bus.i_alu_result = '0; bus.i_zero = 1'b0; bus.i_write_data = '0;
    bus.i_rd_addr = '0; bus.i_pc_link = '0; bus.i_branch_target = '0;
    bus.i_branch = 1'b0; bus.i_link = 1'b0; bus.i_mem_read = 1'b0;
    bus.i_mem_write = 1'b0; bus.i_mem_size = 2'b10; bus.i_mem_unsigned = 1'b0;
    bus.i_mem_to_reg = 1'b0; bus.i_reg_write = 1'b0; bus.i_halt = 1'b0;
  endtask

  // Queue the expectation for the inputs now applied, clock once, then compare.
  task automatic step(input string tag);
    exp_t e;
    e = bus.i_enable ? model() : last_exp;
    sb.push_back(e);
    last_exp = e;
    @(posedge i_clock);
    #1;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      check_all(tag, sb.pop_front());
    end
  endtask

  initial begin
    exp_t snap;
    clear_inputs();
    last_exp = '0;
    #3;
    check_all("reset", '0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;

    // BEQ taken / not taken
    bus.i_branch = 1'b1; bus.i_zero = 1'b1; bus.i_branch_target = 32'h40;
    step("beq_taken");
    check("beq_taken.pcsrc_k", 32'(bus.o_pcsrc), 32'd1);
    check("beq_taken.target_k", bus.o_branch_target, 32'h40);
    bus.i_zero = 1'b0;
    step("beq_not");
    check("beq_not.pcsrc_k", 32'(bus.o_pcsrc), 32'd0);

    // SB at lane 3
    clear_inputs();
    bus.i_alu_result = 32'h1003; bus.i_write_data = 32'hAABBCCDD;
    bus.i_mem_size = 2'b00; bus.i_mem_write = 1'b1;
    step("sb");
    check("sb.data_k", bus.o_store_data, 32'hDDDDDDDD);
    check("sb.be_k", 32'(bus.o_byte_en), 32'h8);
    check("sb.mis_k", 32'(bus.o_misaligned), 32'd0);

    // SH misaligned
    bus.i_alu_result = 32'h1001; bus.i_mem_size = 2'b01;
    step("sh_mis");
    check("sh_mis.wr_k", 32'(bus.o_mem_write), 32'd0);
    check("sh_mis.be_k", 32'(bus.o_byte_en), 32'd0);
    check("sh_mis.mis_k", 32'(bus.o_misaligned), 32'd1);

    // SH aligned upper half
    bus.i_alu_result = 32'h1002;
    step("sh_hi");
    check("sh_hi.be_k", 32'(bus.o_byte_en), 32'hC);

    // JAL
    clear_inputs();
    bus.i_link = 1'b1; bus.i_pc_link = 32'h24; bus.i_alu_result = 32'h99;
    bus.i_reg_write = 1'b1; bus.i_rd_addr = 5'd31;
    step("jal");
    check("jal.result_k", bus.o_result, 32'h24);
    check("jal.rd_k", 32'(bus.o_rd_addr), 32'd31);
    check("jal.rw_k", 32'(bus.o_reg_write), 32'd1);

    // Stall three edges with changing inputs, then flush
    snap = last_exp;
    bus.i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_alu_result = $urandom; bus.i_link = 1'b0; bus.i_halt = 1'b1;
      bus.i_flush = i[0]; bus.i_mem_read = 1'b1;
      step("stall");
    end
    check("stall.result_k", bus.o_result, snap.result);
    bus.i_enable = 1'b1; bus.i_flush = 1'b1; bus.i_reg_write = 1'b1;
    step("flush");
    check("flush.rw_k", 32'(bus.o_reg_write), 32'd0);
    check("flush.halt_k", 32'(bus.o_halt), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      bus.i_enable = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 5) == 0);
      bus.i_alu_result = $urandom; bus.i_zero = 1'($urandom);
      bus.i_write_data = $urandom; bus.i_rd_addr = 5'($urandom);
      bus.i_pc_link = $urandom; bus.i_branch_target = $urandom;
      bus.i_branch = 1'($urandom);
      bus.i_link = bus.i_branch ? 1'b0 : 1'($urandom);
      bus.i_mem_read = 1'($urandom); bus.i_mem_write = 1'($urandom);
      bus.i_mem_size = 2'($urandom); bus.i_mem_unsigned = 1'($urandom);
      bus.i_mem_to_reg = 1'($urandom); bus.i_reg_write = 1'($urandom);
      bus.i_halt = 1'($urandom);
      step("rand");
    end

    // Async reset between edges
    clear_inputs();
    bus.i_alu_result = 32'h1234; bus.i_reg_write = 1'b1;
    step("pre_rst");
    #2;
    i_reset = 1'b1;
    #1;
    check_all("async_rst", '0);
    @(posedge i_clock); #1;
    check_all("rst_hold", '0);
    i_reset = 1'b0;
    last_exp = '0;
    step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
